// File: rtl/full_adder.sv
// Registered ripple-carry adder: {cout,sum} = a + b + cin with one cycle of latency.
// Defining FULL_ADDER_OVF_EN adds a registered signed-overflow output, ovf.
module full_adder #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef FULL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_next;

    // The whole ripple chain sits in one process so the carry vector is one combinational net
    always_comb begin
        carry    = '0;
        sum_next = '0;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum_next[i]  = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

`ifdef FULL_ADDER_OVF_EN
    logic ovf_next;

    always_comb begin
        ovf_next = (a[WIDTH-1] == b[WIDTH-1]) & (sum_next[WIDTH-1] != a[WIDTH-1]);
    end
`endif

    // Result registers load only on qualified cycles, so idle operands never reach the outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_next;
                cout <= carry[WIDTH];
`ifdef FULL_ADDER_OVF_EN
                ovf  <= ovf_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: WIDTH=1, 8 and 16 instances checked each cycle against an arithmetic model,
// plus directed vectors with hand-computed results. Build with FULL_ADDER_OVF_EN to include ovf.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic        ov1, s1, co1;
    logic        v8 = 1'b0, c8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, s8;
    logic        ov8, co8;
    logic        v16 = 1'b0, c16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, s16;
    logic        ov16, co16;

    logic        m1_v, m1_s, m1_co;
    logic        m8_v, m8_co;
    logic [7:0]  m8_s;
    logic        m16_v, m16_co;
    logic [15:0] m16_s;
`ifdef FULL_ADDER_OVF_EN
    logic of1, of8, of16;
    logic m1_of, m8_of, m16_of;
`endif

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
        .out_valid(ov1), .sum(s1), .cout(co1)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(of1)
`endif
    );

    full_adder #(.WIDTH(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
        .out_valid(ov8), .sum(s8), .cout(co8)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(of8)
`endif
    );

    full_adder #(.WIDTH(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16), .cin(c16),
        .out_valid(ov16), .sum(s16), .cout(co16)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(of16)
`endif
    );

    // Overflow from the signed value range rather than from bit patterns
    function automatic logic signedOverflow(input longint av, input longint bv, input logic c, input int w);
        longint lim, sa, sb, s;
        lim = longint'(1) << (w - 1);
        sa  = (av >= lim) ? av - 2 * lim : av;
        sb  = (bv >= lim) ? bv - 2 * lim : bv;
        s   = sa + sb + longint'(c);
        return (s >= lim) || (s < -lim);
    endfunction

    // Reference model: plain integer addition with the same one-cycle result timing
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_v <= 1'b0;  m1_s <= 1'b0;  m1_co <= 1'b0;
            m8_v <= 1'b0;  m8_s <= '0;    m8_co <= 1'b0;
            m16_v <= 1'b0; m16_s <= '0;   m16_co <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
            m1_of <= 1'b0; m8_of <= 1'b0; m16_of <= 1'b0;
`endif
        end else begin
            m1_v  <= v1;
            m8_v  <= v8;
            m16_v <= v16;
            if (v1) begin
                {m1_co, m1_s} <= 2'(a1) + 2'(b1) + 2'(c1);
`ifdef FULL_ADDER_OVF_EN
                m1_of <= signedOverflow(longint'(a1), longint'(b1), c1, 1);
`endif
            end
            if (v8) begin
                {m8_co, m8_s} <= 9'(a8) + 9'(b8) + 9'(c8);
`ifdef FULL_ADDER_OVF_EN
                m8_of <= signedOverflow(longint'(a8), longint'(b8), c8, 8);
`endif
            end
            if (v16) begin
                {m16_co, m16_s} <= 17'(a16) + 17'(b16) + 17'(c16);
`ifdef FULL_ADDER_OVF_EN
                m16_of <= signedOverflow(longint'(a16), longint'(b16), c16, 16);
`endif
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int w, input logic v, input logic [15:0] a, input logic [15:0] b,
                                 input logic c);
        case (w)
            1:       begin v1 = v;  a1 = a[0];    b1 = b[0];    c1 = c;  end
            8:       begin v8 = v;  a8 = a[7:0];  b8 = b[7:0];  c8 = c;  end
            default: begin v16 = v; a16 = a;      b16 = b;      c16 = c; end
        endcase
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("d1_valid", 64'(ov1), 64'(m1_v));
            checkOutput("d1_sum", 64'(s1), 64'(m1_s));
            checkOutput("d1_cout", 64'(co1), 64'(m1_co));
            checkOutput("d8_valid", 64'(ov8), 64'(m8_v));
            checkOutput("d8_sum", 64'(s8), 64'(m8_s));
            checkOutput("d8_cout", 64'(co8), 64'(m8_co));
            checkOutput("d16_valid", 64'(ov16), 64'(m16_v));
            checkOutput("d16_sum", 64'(s16), 64'(m16_s));
            checkOutput("d16_cout", 64'(co16), 64'(m16_co));
`ifdef FULL_ADDER_OVF_EN
            checkOutput("d1_ovf", 64'(of1), 64'(m1_of));
            checkOutput("d8_ovf", 64'(of8), 64'(m8_of));
            checkOutput("d16_ovf", 64'(of16), 64'(m16_of));
`endif
        end
    end

    initial begin
        logic [1:0] truth [8];
        logic [2:0] bits;
        truth = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        // Reset state while rst_n is held low across an edge
        @(posedge clk);
        #2;
        checkOutput("rst_valid", 64'(ov8), 64'd0);
        checkOutput("rst_sum", 64'(s16), 64'd0);
        checkOutput("rst_cout", 64'(co8), 64'd0);
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // One-bit truth table, back to back
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            bits = 3'(i);
            applyStimulus(1, 1'b1, 16'(bits[2]), 16'(bits[1]), bits[0]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("tt_%0d", i), 64'({co1, s1}), 64'(truth[i]));
            checkOutput($sformatf("tt_valid_%0d", i), 64'(ov1), 64'd1);
        end
        @(negedge clk);
        #1;
        applyStimulus(1, 1'b0, 16'h0, 16'h0, 1'b0);

        applyStimulus(8, 1'b1, 16'h00FF, 16'h0000, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("ff_plus_cin", 64'({ov8, co8, s8}), 64'h300);
        checkOutput("model_ff_plus_cin", 64'({m8_co, m8_s}), 64'h100);

        @(negedge clk);
        #1;
        applyStimulus(8, 1'b1, 16'h007F, 16'h0001, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("7f_plus_01", 64'({co8, s8}), 64'h080);
`ifdef FULL_ADDER_OVF_EN
        checkOutput("7f_plus_01_ovf", 64'(of8), 64'd1);
`endif

        @(negedge clk);
        #1;
        applyStimulus(8, 1'b1, 16'h0080, 16'h0080, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("80_plus_80", 64'({co8, s8}), 64'h100);
`ifdef FULL_ADDER_OVF_EN
        checkOutput("80_plus_80_ovf", 64'(of8), 64'd1);
`endif

        @(negedge clk);
        #1;
        applyStimulus(8, 1'b1, 16'h00FF, 16'h00FF, 1'b1);
        applyStimulus(16, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("max_wrap8", 64'({co8, s8}), 64'h1FF);
        checkOutput("max_wrap16", 64'({co16, s16}), 64'h1FFFF);

        // Hold a result while idle operands wander, including unknowns
        @(negedge clk);
        #1;
        applyStimulus(8, 1'b1, 16'h0050, 16'h000A, 1'b0);
        applyStimulus(16, 1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("load_5a", 64'({ov8, co8, s8}), 64'h25A);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (i == 1) applyStimulus(8, 1'b0, 16'hxxxx, 16'hxxxx, 1'bx);
            else        applyStimulus(8, 1'b0, 16'($urandom), 16'($urandom), 1'b1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("hold_5a_%0d", i), 64'({ov8, co8, s8}), 64'h05A);
        end

        // Asynchronous reset between edges, then a fresh valid is required
        @(negedge clk);
        #1;
        applyStimulus(8, 1'b1, 16'h0001, 16'h0002, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("pre_reset", 64'({ov8, co8, s8}), 64'h203);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 64'({ov8, co8, s8}), 64'h000);
        @(negedge clk);
        #1;
        applyStimulus(8, 1'b0, 16'h0011, 16'h0022, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("after_reset_idle", 64'({ov8, co8, s8}), 64'h000);
        @(negedge clk);
        #1;
        applyStimulus(8, 1'b1, 16'h0010, 16'h0020, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("fresh_after_reset", 64'({ov8, co8, s8}), 64'h231);

        // Random streams on all widths, checked cycle by cycle against the model
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            applyStimulus(1, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
            applyStimulus(8, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
            applyStimulus(16, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        end
        @(negedge clk);
        #1;
        applyStimulus(1, 1'b0, 16'h0, 16'h0, 1'b0);
        applyStimulus(8, 1'b0, 16'h0, 16'h0, 1'b0);
        applyStimulus(16, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, default 1, operand/sum bit width (legal range 1..64).
REQ-002 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 Port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 Port in_valid, input, 1, operands a/b/cin qualified this cycle.
REQ-005 Port a, input, WIDTH, addend A, unsigned (two's complement for ovf).
REQ-006 Port b, input, WIDTH, addend B.
REQ-007 Port cin, input, 1, carry into bit 0.
REQ-008 Port out_valid, output, 1, registered; sum/cout (and ovf) valid this cycle.
REQ-009 Port sum, output, WIDTH, registered sum bits.
REQ-010 Port cout, output, 1, registered carry out of bit WIDTH-1.
REQ-011 Port ovf, output, 1, registered signed overflow; present only when FULL_ADDER_OVF_EN defined.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin, full WIDTH+1-bit result, no truncation of carry.
REQ-013 Per-bit logic SHALL be the classic cell: s_i = a_i ^ b_i ^ c_i; c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i)); c_0 = cin; ripple structure.
REQ-014 Latency SHALL be exactly 1 cycle: operands sampled at edge N with in_valid=1 appear on sum/cout with out_valid=1 after edge N.
REQ-015 out_valid SHALL equal in_valid registered one cycle; no backpressure, no ready signal.
REQ-016 When in_valid=0 at an edge, sum/cout/ovf SHALL hold their previous values and out_valid SHALL be 0.
REQ-017 Back-to-back in_valid=1 cycles SHALL produce one result per cycle, full throughput.
REQ-018 For WIDTH=1 the block SHALL behave as a registered 1-bit full adder (truth table: sum = a^b^cin, cout = majority(a,b,cin)).
REQ-019 All-ones operands with cin=1 SHALL yield sum = all-ones, cout=1 (maximum wrap case).
REQ-020 X/Z on a/b/cin while in_valid=0 SHALL NOT affect registered outputs.

Reset
REQ-021 rst_n=0 SHALL asynchronously clear sum to 0, cout to 0, out_valid to 0, ovf to 0, independent of clk.
REQ-022 Reset asserted mid-stream SHALL discard any in-flight result; first valid result after deassertion requires a fresh in_valid=1 edge.
REQ-023 Deassertion SHALL take effect at the first rising clk edge with rst_n=1.

Configuration
REQ-024 Macro FULL_ADDER_OVF_EN defined: port ovf exists and SHALL register ovf = (a[W-1] == b[W-1]) & (sum_next[W-1] != a[W-1]), updated/held like sum.
REQ-025 Macro FULL_ADDER_OVF_EN undefined: port ovf and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-026 WIDTH=1, in_valid=1, apply {a,b,cin} = 000..111 one per cycle -> next cycle {cout,sum} = 00,01,01,10,01,10,10,11.
REQ-027 WIDTH=8, a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1, out_valid=1 one cycle later.
REQ-028 WIDTH=8, a=8'h7F, b=8'h01, cin=0 with FULL_ADDER_OVF_EN -> sum=8'h80, cout=0, ovf=1; a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
REQ-029 Valid result 8'h5A held, then in_valid=0 for 3 cycles with random a/b -> sum stays 8'h5A, out_valid=0.
REQ-030 Pull rst_n low between clk edges while out_valid=1 -> sum=0, cout=0, out_valid=0 immediately, before next edge.
REQ-031 Random WIDTH=16 stream, 1000 cycles, in_valid random -> sum/cout match a+b+cin reference model with 1-cycle latency.
